// File: rtl/key_debounce_pkg.sv
// key_pkg: shared types and constants for the key_debounce block.
//   key_state_e            debouncer FSM state encoding
//   DEBOUNCE_CYCLES_DEF    default stable-level time (20 ms at 12 MHz)
//   LONG_PRESS_CYCLES_DEF  default long-press hold time (1 s at 12 MHz)
//   PRESS_CNT_W            width of the press counter shown on LEDs
//   press_cnt_inc()        modulo-256 press counter increment (wraps silently)
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_e;

  localparam int DEBOUNCE_CYCLES_DEF   = 240_000;
  localparam int LONG_PRESS_CYCLES_DEF = 12_000_000;
  localparam int PRESS_CNT_W           = 8;

  function automatic logic [PRESS_CNT_W-1:0] press_cnt_inc(input logic [PRESS_CNT_W-1:0] cnt);
    return cnt + PRESS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce_if.sv
// key_debounce_if: debounced key event bundle.
//   key_level    debounced level, 1 = pressed
//   key_press    one-cycle pulse on debounced press
//   key_release  one-cycle pulse on debounced release
//   long_press   one-cycle pulse once a press has been held long enough
//   press_cnt    count of debounced presses (wraps at 256)
// master: the debouncer driving the events; slave: any consumer.
interface key_debounce_if;

  logic                            key_level;
  logic                            key_press;
  logic                            key_release;
  logic                            long_press;
  logic [key_pkg::PRESS_CNT_W-1:0] press_cnt;

  modport master (
    output key_level,
    output key_press,
    output key_release,
    output long_press,
    output press_cnt
  );

  modport slave (
    input key_level,
    input key_press,
    input key_release,
    input long_press,
    input press_cnt
  );

endinterface

// File: rtl/key_debounce_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit.
//   clk_in    destination clock
//   rst_n_in  asynchronous active-low reset; both flops reset to 1
//             (the idle level of an active-low key)
//   d         asynchronous input
//   q         synchronized output
module sync_2ff (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage resynchronization chain.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/key_debounce.sv
// key_debounce: push-button debouncer with press/release/long-press events.
//   clk_in    system clock (12 MHz)
//   rst_n_in  asynchronous active-low reset
//   key_n_in  raw active-low push-button, asynchronous, may bounce
//   out_if    key_debounce_if.master: key_level, key_press, key_release,
//             long_press, press_cnt (all registered)
// Optional feature: define KEY_LONG_PRESS_EN to build the hold counter and
// long_press pulse; when undefined, long_press is tied to 0.
module key_debounce
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            key_n_in,
  key_debounce_if.master  out_if
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("key_debounce: illegal DEBOUNCE_CYCLES/LONG_PRESS_CYCLES");
  end

  logic                   key_s;
  key_state_e             state_r;
  logic [CNT_W-1:0]       cnt_r;
  logic                   key_level_r;
  logic                   key_press_r;
  logic                   key_release_r;
  logic [PRESS_CNT_W-1:0] press_cnt_r;

  sync_2ff u_sync (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .d        (key_n_in),
    .q        (key_s)
  );

`ifdef KEY_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_r;
  logic              long_done_r;  // hold counter saturated; one pulse per press
  logic              long_press_r;
`endif

  // Debounce FSM with its debounce counter, hold counter and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_r       <= IDLE;
      cnt_r         <= {CNT_W{1'b0}};
      key_level_r   <= 1'b0;
      key_press_r   <= 1'b0;
      key_release_r <= 1'b0;
      press_cnt_r   <= {PRESS_CNT_W{1'b0}};
`ifdef KEY_LONG_PRESS_EN
      hold_r        <= {HOLD_W{1'b0}};
      long_done_r   <= 1'b0;
      long_press_r  <= 1'b0;
`endif
    end else begin
      key_press_r   <= 1'b0;
      key_release_r <= 1'b0;
`ifdef KEY_LONG_PRESS_EN
      long_press_r  <= 1'b0;
`endif
      case (state_r)
        IDLE: begin
          if (!key_s) begin
            state_r <= PRESS_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        PRESS_WAIT: begin
          if (key_s) begin
            state_r <= IDLE;  // bounce: abandon without a pulse
          end else if (cnt_r == CNT_MAX) begin
            state_r     <= PRESSED;
            key_press_r <= 1'b1;
            key_level_r <= 1'b1;
            press_cnt_r <= press_cnt_inc(press_cnt_r);
`ifdef KEY_LONG_PRESS_EN
            hold_r      <= {HOLD_W{1'b0}};
            long_done_r <= 1'b0;
`endif
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (key_s) begin
            state_r <= RELEASE_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
          end else begin
`ifdef KEY_LONG_PRESS_EN
            if (!long_done_r) begin
              if (hold_r == HOLD_MAX) begin
                long_press_r <= 1'b1;
                long_done_r  <= 1'b1;
              end else begin
                hold_r <= hold_r + HOLD_W'(1);
              end
            end
`endif
          end
        end
        RELEASE_WAIT: begin
          // Hold counter is left untouched here so a bounce back resumes it.
          if (!key_s) begin
            state_r <= PRESSED;
          end else if (cnt_r == CNT_MAX) begin
            state_r       <= IDLE;
            key_release_r <= 1'b1;
            key_level_r   <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign out_if.key_level   = key_level_r;
  assign out_if.key_press   = key_press_r;
  assign out_if.key_release = key_release_r;
  assign out_if.press_cnt   = press_cnt_r;
`ifdef KEY_LONG_PRESS_EN
  assign out_if.long_press  = long_press_r;
`else
  assign out_if.long_press  = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce: scoreboard bench for key_debounce (DEBOUNCE_CYCLES=8,
// LONG_PRESS_CYCLES=32). A reference model predicts pulse events from the
// run length of the synchronized key level; a monitor matches DUT pulses
// against the expected-event queue. Honours KEY_LONG_PRESS_EN.
module tb_key_debounce;

  localparam int DEB  = 8;
  localparam int LONG = 32;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  typedef struct {
    int kind;    // 0 press, 1 release, 2 long press
    int edge_i;  // clock edge on which the pulse is registered
    int cnt;     // press_cnt expected alongside a press pulse
  } ev_t;

  logic clk;
  logic rst_n;
  logic key_n;

  key_debounce_if kif ();

  key_debounce #(
    .DEBOUNCE_CYCLES   (DEB),
    .LONG_PRESS_CYCLES (LONG)
  ) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .key_n_in (key_n),
    .out_if   (kif)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model state
  ev_t        exp_q[$];
  int         dly[$];
  int         edge_no = 0;
  bit         m_level;
  int         m_run;
  int         m_hold;
  logic [7:0] m_cnt;
  int         ks;

  // Observed events
  int press_seen = 0, release_seen = 0, long_seen = 0;
  int press_edge = 0, long_edge = 0;

  task automatic mdl_reset();
    dly.delete();
    dly.push_back(1);
    dly.push_back(1);
    m_level = 1'b0;
    m_run   = 0;
    m_hold  = 0;
    m_cnt   = 8'd0;
  endtask

  // Model: level flips after DEB+1 consecutive synchronized samples disagree with it.
  initial begin
    mdl_reset();
    forever begin
      @(posedge clk);
      edge_no++;
      if (!rst_n) begin
        mdl_reset();
      end else begin
        ks = dly.pop_front();
        dly.push_back(int'(key_n));
        if (m_level && m_run == 0 && ks == 0) begin
          m_hold++;
          if (LONG_EN && m_hold == LONG) exp_q.push_back('{2, edge_no, 0});
        end
        if ((ks == 0) != m_level) m_run++;
        else m_run = 0;
        if (m_run == DEB + 1) begin
          m_run   = 0;
          m_level = !m_level;
          if (m_level) begin
            m_cnt  = m_cnt + 8'd1;
            m_hold = 0;
            exp_q.push_back('{0, edge_no, int'(m_cnt)});
          end else begin
            exp_q.push_back('{1, edge_no, 0});
          end
        end
      end
    end
  end

  // Monitor: compare level/count each cycle and match pulses to the queue.
  initial begin
    ev_t e;
    int  kind;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        while (exp_q.size() > 0 && exp_q[0].edge_i < edge_no) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missed_pulse: got none, expected kind %0d at edge %0d", e.kind, e.edge_i);
        end
        chk("key_level", int'(kif.key_level), int'(m_level));
        chk("press_cnt", int'(kif.press_cnt), int'(m_cnt));
        if (kif.key_press || kif.key_release || kif.long_press) begin
          chk("one_pulse", $countones({kif.key_press, kif.key_release, kif.long_press}), 1);
          if (kif.key_press) begin
            kind = 0; press_seen++; press_edge = edge_no;
          end else if (kif.key_release) begin
            kind = 1; release_seen++;
          end else begin
            kind = 2; long_seen++; long_edge = edge_no;
          end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got kind %0d at edge %0d, expected none", kind, edge_no);
          end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", kind, e.kind);
            chk("pulse_edge", edge_no, e.edge_i);
            if (kind == 0) chk("press_cnt_at_press", int'(kif.press_cnt), e.cnt);
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input int n);
    key_n = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_level(input int n);
    int i;
    i = 0;
    while (!kif.key_level && i < n) begin
      @(negedge clk);
      i++;
    end
    if (!kif.key_level) chk("wait_level_timeout", 0, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   int'(kif.key_level),   0);
    chk({tag, "_press"},   int'(kif.key_press),   0);
    chk({tag, "_release"}, int'(kif.key_release), 0);
    chk({tag, "_long"},    int'(kif.long_press),  0);
    chk({tag, "_cnt"},     int'(kif.press_cnt),   0);
  endtask

  int p0, r0, l0, start;

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Clean press then clean release
    @(negedge clk);
    p0 = press_seen; r0 = release_seen;
    start = edge_no + 1;
    drive(1'b0, 20);
    chk("clean_press_count", press_seen - p0, 1);
    chk("clean_press_latency", press_edge - start, 10);
    chk("clean_level", int'(kif.key_level), 1);
    chk("clean_cnt", int'(kif.press_cnt), 1);
    drive(1'b1, 20);
    chk("clean_release_count", release_seen - r0, 1);

    // Press bounce
    do_reset();
    p0 = press_seen;
    drive(1'b0, 3); drive(1'b1, 1); drive(1'b0, 3); drive(1'b1, 20);
    chk("bounce_press_count", press_seen - p0, 0);
    chk("bounce_level", int'(kif.key_level), 0);
    chk("bounce_cnt", int'(kif.press_cnt), 0);

    // Release bounce
    drive(1'b0, 20);
    r0 = release_seen;
    drive(1'b1, 5); drive(1'b0, 5);
    chk("rel_bounce_count", release_seen - r0, 0);
    chk("rel_bounce_level", int'(kif.key_level), 1);
    drive(1'b1, 12);
    chk("release_count", release_seen - r0, 1);
    chk("release_level", int'(kif.key_level), 0);
    drive(1'b1, 5);

    // Long press
    l0 = long_seen;
    drive(1'b0, 60);
    chk("long_count", long_seen - l0, LONG_EN ? 1 : 0);
    if (LONG_EN) chk("long_latency", long_edge - press_edge, LONG);
    drive(1'b1, 20);

    // Randomized bursts
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(1, 45));
    end
    drive(1'b1, 20);

    // Reset while pressed
    drive(1'b0, 1);
    wait_level(30);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    r0 = release_seen; p0 = press_seen;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    start = edge_no + 1;
    repeat (15) @(negedge clk);
    chk("midreset_release", release_seen - r0, 0);
    chk("midreset_press", press_seen - p0, 1);
    chk("midreset_latency", press_edge - start, 10);
    drive(1'b1, 20);

    // Counter wrap
    do_reset();
    p0 = press_seen;
    for (int i = 0; i < 256; i++) begin
      drive(1'b0, 12);
      drive(1'b1, 12);
    end
    chk("wrap_presses", press_seen - p0, 256);
    chk("wrap_cnt", int'(kif.press_cnt), 0);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
